// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: access sizes, MEM-stage FSM encoding,
// MEM-stage request/writeback records and the alignment predicate.
package mips_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2
  } mem_state_e;

  // Access captured when a load/store enters the MEM stage.
  typedef struct packed {
    logic       store;
    logic [1:0] size;
    logic       uns;
    logic [1:0] lo;        // low address bits after any lane-0 forcing
    logic [4:0] rd;
    logic       reg_write;
  } mem_req_t;

  // Registered writeback bundle.
  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
  } wb_t;

  // Half must be 2-byte aligned, word must be 4-byte aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SZ_HALF) && lo[0]) || ((size == SZ_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational byte-lane logic for the MEM stage: store byte enables and
// lane-replicated write data, plus load lane extraction and sign/zero extend.
// LITTLE_ENDIAN=0 mirrors the byte lane index (lane = 3 - addr[1:0]).
module mem_load_align
  import mips_pkg::*;
#(
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_rep,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lo,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  localparam int NUM_LANES = 4;

  logic [1:0]                 st_lane, ld_lane;
  logic                       st_hsel, ld_hsel;
  logic [NUM_LANES-1:0][7:0]  rbytes;
  logic [1:0][15:0]           rhalves;
  logic [7:0]                 ld_byte;
  logic [15:0]                ld_half;

  assign st_lane = LITTLE_ENDIAN ? st_lo : (2'd3 - st_lo);
  assign ld_lane = LITTLE_ENDIAN ? ld_lo : (2'd3 - ld_lo);
  // Upper half sits in bits[31:16] for little-endian addr[1]=1, big-endian addr[1]=0.
  assign st_hsel = LITTLE_ENDIAN ? st_lo[1] : ~st_lo[1];
  assign ld_hsel = LITTLE_ENDIAN ? ld_lo[1] : ~ld_lo[1];

  assign rbytes  = ld_rdata;
  assign rhalves = ld_rdata;
  assign ld_byte = rbytes[ld_lane];
  assign ld_half = rhalves[ld_hsel];

  // Store side: enables follow the lane, data is replicated to every lane.
  always_comb begin
    st_be        = 4'b1111;
    st_wdata_rep = st_wdata;
    case (st_size)
      SZ_BYTE: begin
        st_be        = 4'b0001 << st_lane;
        st_wdata_rep = {4{st_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_be        = st_hsel ? 4'b1100 : 4'b0011;
        st_wdata_rep = {2{st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load side: pick the lane and extend; word ignores the unsigned flag.
  always_comb begin
    ld_data = ld_rdata;
    case (ld_size)
      SZ_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the five-stage MIPS pipeline. Non-memory ops retire one cycle
// after entry; loads/stores drive a valid/ready data-memory port and stall
// upstream until they complete. All outputs except stall_o are registered.
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned half/word accesses are
// not issued and retire with exc_misalign=1. Without it, offending low address
// bits are forced to lane 0 and exc_misalign stays 0.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [1:0]        ex_size,
  input  logic              ex_unsigned,
  input  logic [31:0]       ex_alu_out,
  input  logic [31:0]       ex_wdata,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_write,
  output logic              stall_o,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ready,
  input  logic              dm_rvalid,
  input  logic [31:0]       dm_rdata,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              exc_misalign
);

  mem_state_e        state_q, state_d;
  mem_req_t          req_q, req_d;
  wb_t               wb_q, wb_d;
  logic              dm_req_q, dm_req_d;
  logic              dm_we_q, dm_we_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [3:0]        dm_be_q, dm_be_d;
  logic [31:0]       dm_wdata_q, dm_wdata_d;

  logic              is_mem, mis_op, mem_go;
  logic [1:0]        lo_fix;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata_rep, ld_data;

  assign is_mem = ex_valid & (ex_mem_read | ex_mem_write);

`ifdef MEM_ALIGN_CHECK_EN
  assign mis_op = is_mem & is_misaligned(ex_size, ex_alu_out[1:0]);
  assign lo_fix = ex_alu_out[1:0];
`else
  assign mis_op = 1'b0;
  // Silently align: half drops addr[0], word drops addr[1:0].
  assign lo_fix = (ex_size == SZ_BYTE) ? ex_alu_out[1:0] :
                  (ex_size == SZ_HALF) ? {ex_alu_out[1], 1'b0} : 2'b00;
`endif

  assign mem_go = is_mem & ~mis_op;

  mem_load_align #(.LITTLE_ENDIAN(LITTLE_ENDIAN)) u_align (
    .st_size      (ex_size),
    .st_lo        (lo_fix),
    .st_wdata     (ex_wdata),
    .st_be        (st_be),
    .st_wdata_rep (st_wdata_rep),
    .ld_size      (req_q.size),
    .ld_lo        (req_q.lo),
    .ld_unsigned  (req_q.uns),
    .ld_rdata     (dm_rdata),
    .ld_data      (ld_data)
  );

  // Upstream hold: any in-flight access, released in its completion cycle.
  always_comb begin
    case (state_q)
      MEM_IDLE: stall_o = mem_go;
      MEM_REQ:  stall_o = ~(dm_ready & req_q.store);
      MEM_WAIT: stall_o = ~dm_rvalid;
      default:  stall_o = 1'b0;
    endcase
  end

  // FSM next state plus next values of every registered output.
  always_comb begin
    state_d           = state_q;
    req_d             = req_q;
    wb_d              = wb_q;
    wb_d.valid        = 1'b0;
    wb_d.reg_write    = 1'b0;
    wb_d.exc          = 1'b0;
    dm_req_d          = dm_req_q;
    dm_we_d           = dm_we_q;
    dm_addr_d         = dm_addr_q;
    dm_be_d           = dm_be_q;
    dm_wdata_d        = dm_wdata_q;
    case (state_q)
      MEM_IDLE: begin
        if (mem_go) begin
          req_d.store     = ex_mem_write;
          req_d.size      = ex_size;
          req_d.uns       = ex_unsigned;
          req_d.lo        = lo_fix;
          req_d.rd        = ex_rd;
          req_d.reg_write = ex_reg_write;
          dm_req_d        = 1'b1;
          dm_we_d         = ex_mem_write;
          dm_addr_d       = {ex_alu_out[ADDR_W-1:2], 2'b00};
          dm_be_d         = st_be;
          dm_wdata_d      = st_wdata_rep;
          state_d         = MEM_REQ;
        end else if (ex_valid) begin
          // ALU op, or a rejected misaligned access when checking is built in.
          wb_d.valid     = 1'b1;
          wb_d.reg_write = ex_reg_write & ~mis_op;
          wb_d.rd        = ex_rd;
          wb_d.data      = ex_alu_out;
          wb_d.exc       = mis_op;
        end
      end
      MEM_REQ: begin
        if (dm_ready) begin
          dm_req_d = 1'b0;
          if (req_q.store) begin
            wb_d.valid = 1'b1;
            wb_d.rd    = req_q.rd;
            state_d    = MEM_IDLE;
          end else begin
            state_d = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        if (dm_rvalid) begin
          wb_d.valid     = 1'b1;
          wb_d.reg_write = req_q.reg_write;
          wb_d.rd        = req_q.rd;
          wb_d.data      = ld_data;
          state_d        = MEM_IDLE;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MEM_IDLE;
      req_q      <= '0;
      wb_q       <= '0;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_be_q    <= '0;
      dm_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      wb_q       <= wb_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_be_q    <= dm_be_d;
      dm_wdata_q <= dm_wdata_d;
    end
  end

  assign dm_req       = dm_req_q;
  assign dm_we        = dm_we_q;
  assign dm_addr      = dm_addr_q;
  assign dm_be        = dm_be_q;
  assign dm_wdata     = dm_wdata_q;
  assign wb_valid     = wb_q.valid;
  assign wb_reg_write = wb_q.reg_write;
  assign wb_rd        = wb_q.rd;
  assign wb_data      = wb_q.data;
  assign exc_misalign = wb_q.exc;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus random ops against a
// behavioural model of lane selection, extension and stall occupancy.
module tb_mem_access_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_unsigned, ex_reg_write;
  logic [1:0]  ex_size;
  logic [31:0] ex_alu_out, ex_wdata;
  logic [4:0]  ex_rd;
  logic        stall_o, dm_req, dm_we, dm_ready, dm_rvalid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        wb_valid, wb_reg_write, exc_misalign;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_alu_out(ex_alu_out),
    .ex_wdata(ex_wdata), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .stall_o(stall_o), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ready(dm_ready),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_data(wb_data), .exc_misalign(exc_misalign)
  );

  localparam int K_ALU = 0, K_LD = 1, K_ST = 2;

  typedef struct {
    int          kind;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        rw;
  } op_t;

  typedef struct {
    int          cyc;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
    bit          chk_data;
  } wbx_t;

  wbx_t exp_q[$];
  wbx_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every writeback pulse must match the oldest expected retirement, in its cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wb_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_wb cyc=%0d rd=%0d data=%h, required no writeback", cyc, wb_rd, wb_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (cyc != mon_e.cyc || wb_reg_write !== mon_e.rw || exc_misalign !== mon_e.exc ||
            (mon_e.chk_data && (wb_data !== mon_e.data || wb_rd !== mon_e.rd))) begin
          errors++;
          $display("FAIL wb got cyc=%0d rw=%b rd=%0d data=%h exc=%b, required cyc=%0d rw=%b rd=%0d data=%h exc=%b",
                   cyc, wb_reg_write, wb_rd, wb_data, exc_misalign,
                   mon_e.cyc, mon_e.rw, mon_e.rd, mon_e.data, mon_e.exc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0;
      dm_ready = 0; dm_rvalid = 0;
      @(posedge clk);
    end
  endtask

  // Presents one instruction, plays the memory with the given ready/rvalid
  // delays, checks the port and occupancy, and queues the expected writeback.
  task automatic run_op(input op_t op, input int rdly, input int vdly, input logic [31:0] rdata);
    logic [31:0] ea, xw, xd, v;
    logic [3:0]  xbe;
    bit          mem, mis, go, done, acc, saw;
    int          xocc, occ, rq, since, last;
    wbx_t        w;
    mem = (op.kind != K_ALU);
    mis = mem && ((op.size == SZ_HALF && op.addr % 2 != 0) || (op.size == SZ_WORD && op.addr % 4 != 0));
    ea  = op.addr;
`ifdef MEM_ALIGN_CHECK_EN
    go = mem && !mis;
`else
    go = mem;
    if (op.size == SZ_HALF) ea = ea - (ea % 2);
    if (op.size == SZ_WORD) ea = ea - (ea % 4);
`endif
    xbe = (op.size == SZ_BYTE) ? (4'b0001 << (ea % 4)) : (op.size == SZ_HALF) ? ((ea % 4 >= 2) ? 4'hC : 4'h3) : 4'hF;
    xw  = (op.size == SZ_BYTE) ? (op.wdata & 32'hFF) * 32'h0101_0101 :
          (op.size == SZ_HALF) ? (op.wdata & 32'hFFFF) * 32'h0001_0001 : op.wdata;
    if (op.size == SZ_BYTE) begin
      v = (rdata >> (8 * (ea % 4))) & 32'hFF;
      if (!op.uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (op.size == SZ_HALF) begin
      v = (rdata >> (16 * ((ea % 4) / 2))) & 32'hFFFF;
      if (!op.uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else v = rdata;
    xd   = v;
    xocc = !go ? 1 : (op.kind == K_ST) ? 2 + rdly : 2 + rdly + vdly;

    @(negedge clk);
    ex_valid = 1; ex_mem_read = (op.kind == K_LD); ex_mem_write = (op.kind == K_ST);
    ex_size = op.size; ex_unsigned = op.uns; ex_alu_out = op.addr; ex_wdata = op.wdata;
    ex_rd = op.rd; ex_reg_write = op.rw;
    done = 0; acc = 0; saw = 0; occ = 0; rq = 0; since = 0; last = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      if (k > 0) @(negedge clk);
      dm_ready = 0; dm_rvalid = 0; dm_rdata = $urandom;
      if (dm_req === 1'b1 && !acc) begin
        saw = 1;
        if (rq == rdly) begin
          dm_ready = 1; acc = 1;
          checks++;
          if (dm_addr !== ea - (ea % 4)) begin errors++; $display("FAIL dm_addr got %h, required %h", dm_addr, ea - (ea % 4)); end
          checks++;
          if (dm_be !== xbe) begin errors++; $display("FAIL dm_be got %b, required %b", dm_be, xbe); end
          checks++;
          if (dm_we !== (op.kind == K_ST)) begin errors++; $display("FAIL dm_we got %b, required %b", dm_we, op.kind == K_ST); end
          if (op.kind == K_ST) begin
            checks++;
            if (dm_wdata !== xw) begin errors++; $display("FAIL dm_wdata got %h, required %h", dm_wdata, xw); end
          end
        end
        rq++;
      end else if (acc && op.kind == K_LD) begin
        since++;
        if (since == vdly) begin dm_rvalid = 1; dm_rdata = rdata; end
      end
      #1;
      occ++;
      last = cyc;
      if (stall_o === 1'b0) done = 1;
      @(posedge clk);
    end
    checks++;
    if (!done || occ != xocc) begin
      errors++;
      $display("FAIL occupancy got %0d cycles (done=%0d), required %0d", occ, done, xocc);
    end
    checks++;
    if (saw != go) begin errors++; $display("FAIL dm_req_seen got %0d, required %0d", saw, go); end
    if (done) begin
      w.cyc = last + 1; w.exc = mem && !go; w.rd = op.rd;
      w.rw  = (op.kind == K_ST || !go && mem) ? 1'b0 : op.rw;
      w.data = (op.kind == K_ALU) ? op.addr : xd;
      w.chk_data = (op.kind == K_ALU) || (op.kind == K_LD && go);
      exp_q.push_back(w);
    end
  endtask

  function automatic op_t mk(input int kind, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    op_t o;
    o.kind = kind; o.size = size; o.uns = uns; o.addr = addr; o.wdata = wdata; o.rd = rd;
    o.rw = (kind != K_ST);
    return o;
  endfunction

  task automatic test_reset();
    rst_n = 0; ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_size = 0; ex_unsigned = 0;
    ex_alu_out = 0; ex_wdata = 0; ex_rd = 0; ex_reg_write = 0; dm_ready = 0; dm_rvalid = 0; dm_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({wb_valid, wb_reg_write, wb_rd, wb_data, exc_misalign} !== 39'd0) begin
      errors++; $display("FAIL reset_wb got v=%b rw=%b rd=%0d data=%h exc=%b, required all 0", wb_valid, wb_reg_write, wb_rd, wb_data, exc_misalign);
    end
    checks++;
    if ({dm_req, dm_we, dm_be, dm_addr, dm_wdata} !== 70'd0) begin
      errors++; $display("FAIL reset_dm got req=%b we=%b be=%b addr=%h wdata=%h, required all 0", dm_req, dm_we, dm_be, dm_addr, dm_wdata);
    end
    checks++;
    if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b, required 0", stall_o); end
    @(negedge clk); rst_n = 1;
    @(posedge clk);
  endtask

  task automatic drain_check(input string name);
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL %s_missing_wb got %0d outstanding, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_alu();
    run_op(mk(K_ALU, SZ_WORD, 0, 32'h0000_0005, 0, 5'd3), 0, 0, 0);
    run_op(mk(K_ALU, SZ_BYTE, 0, 32'hDEAD_BEEF, 0, 5'd31), 0, 0, 0);
    idle(1);
    run_op(mk(K_ALU, SZ_HALF, 1, 32'h1234_5678, 0, 5'd7), 0, 0, 0);
    drain_check("alu");
  endtask

  task automatic test_store();
    run_op(mk(K_ST, SZ_BYTE, 0, 32'h0000_0103, 32'h0000_00AB, 5'd0), 0, 0, 0);
    run_op(mk(K_ST, SZ_HALF, 0, 32'h0000_0206, 32'h5555_BEEF, 5'd0), 2, 0, 0);
    run_op(mk(K_ST, SZ_WORD, 0, 32'h0000_0400, 32'hCAFE_F00D, 5'd0), 1, 0, 0);
    drain_check("store");
  endtask

  task automatic test_load();
    run_op(mk(K_LD, SZ_BYTE, 0, 32'h0000_0102, 0, 5'd4), 3, 2, 32'h0080_0000);
    run_op(mk(K_LD, SZ_BYTE, 1, 32'h0000_0102, 0, 5'd4), 3, 2, 32'h0080_0000);
    run_op(mk(K_LD, SZ_HALF, 0, 32'h0000_0202, 0, 5'd9), 0, 1, 32'h9ABC_1234);
    run_op(mk(K_LD, SZ_HALF, 1, 32'h0000_0200, 0, 5'd9), 0, 1, 32'h1234_F00D);
    run_op(mk(K_LD, SZ_WORD, 1, 32'h0000_0300, 0, 5'd10), 1, 3, 32'h8765_4321);
    drain_check("load");
  endtask

  task automatic test_back_to_back();
    run_op(mk(K_LD, SZ_WORD, 0, 32'h0000_0040, 0, 5'd5), 0, 1, 32'h1111_2222);
    run_op(mk(K_ALU, SZ_WORD, 0, 32'h0000_0077, 0, 5'd6), 0, 0, 0);
    run_op(mk(K_ST, SZ_WORD, 0, 32'h0000_0044, 32'h3333_4444, 5'd0), 0, 0, 0);
    run_op(mk(K_ALU, SZ_WORD, 0, 32'h0000_0088, 0, 5'd8), 0, 0, 0);
    drain_check("b2b");
  endtask

  task automatic test_reset_mid();
    exp_q.delete();
    @(negedge clk);
    ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0; ex_size = SZ_WORD; ex_alu_out = 32'h200;
    ex_rd = 5'd2; ex_reg_write = 1; dm_ready = 0; dm_rvalid = 0;
    @(negedge clk); dm_ready = 1;
    @(negedge clk); dm_ready = 0;
    #1;
    checks++;
    if (stall_o !== 1'b1) begin errors++; $display("FAIL wait_stall got %b, required 1", stall_o); end
    #2 rst_n = 0; ex_valid = 0; ex_mem_read = 0;
    #1;
    checks++;
    if ({dm_req, dm_be, dm_addr, wb_valid, stall_o} !== 38'd0) begin
      errors++; $display("FAIL rst_wait got req=%b be=%b addr=%h wbv=%b stall=%b, required all 0", dm_req, dm_be, dm_addr, wb_valid, stall_o);
    end
    @(negedge clk); rst_n = 1;
    @(negedge clk); dm_rvalid = 1; dm_rdata = 32'h1234_5678;
    @(negedge clk); dm_rvalid = 0;
    // store parked in REQ: reset must drop dm_req without a clock
    ex_valid = 1; ex_mem_write = 1; ex_size = SZ_BYTE; ex_alu_out = 32'h301; ex_wdata = 32'h5A;
    @(negedge clk);
    #1;
    checks++;
    if (dm_req !== 1'b1) begin errors++; $display("FAIL req_before_rst got %b, required 1", dm_req); end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({dm_req, dm_we} !== 2'b00) begin errors++; $display("FAIL rst_req got req=%b we=%b, required 0 0", dm_req, dm_we); end
    @(negedge clk); rst_n = 1; ex_valid = 0; ex_mem_write = 0;
    @(posedge clk);
    run_op(mk(K_ALU, SZ_WORD, 0, 32'h0000_0ABC, 0, 5'd12), 0, 0, 0);
    run_op(mk(K_LD, SZ_BYTE, 1, 32'h0000_0201, 0, 5'd13), 0, 1, 32'h0000_FF00);
    drain_check("rst_mid");
  endtask

  task automatic test_misalign();
    run_op(mk(K_LD, SZ_WORD, 0, 32'h0000_0102, 0, 5'd14), 0, 1, 32'hA5A5_0F0F);
    run_op(mk(K_ST, SZ_HALF, 0, 32'h0000_0105, 32'h0000_1234, 5'd0), 0, 0, 0);
    run_op(mk(K_LD, SZ_HALF, 0, 32'h0000_0203, 0, 5'd15), 1, 1, 32'h8001_7002);
    drain_check("misalign");
  endtask

  task automatic test_random();
    op_t o;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 5) == 0) idle(1);
      o = mk($urandom_range(0, 2), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, 5'($urandom_range(0, 31)));
      o.rw = (o.kind == K_ST) ? 1'b0 : 1'($urandom_range(0, 1));
      run_op(o, $urandom_range(0, 3), $urandom_range(1, 3), $urandom);
    end
    drain_check("random");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_back_to_back();
    test_reset_mid();
    test_misalign();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
